// File: rtl/ilm_pkg.sv
// Shared types and helpers for the ILM operand pipeline (16-bit nearest-one detection).
package ilm_pkg;

    localparam int W     = 16;
    localparam int EXP_W = 5;
    localparam int OH_W  = W - 1;
    localparam int P_W   = 4;

    typedef struct packed {
        logic [OH_W-1:0]  onehot;
        logic [EXP_W-1:0] exp;
        logic [W-1:0]     res;
        logic             zero;
        logic             ovf;
    } nod_result_t;

    // Rounding happens only when a bit exists below the leading one and that bit is set.
    function automatic logic [EXP_W-1:0] nearest_exp(input logic [P_W-1:0] p, input logic below_bit);
        logic up;
        up = (p != '0) && below_bit;
        return {1'b0, p} + {{(EXP_W-1){1'b0}}, up};
    endfunction

endpackage

// File: rtl/ilm_nod_stage_if.sv
// Operand-in / result-out bundle of the nearest-one detector stage.
interface ilm_nod_stage_if #(
    parameter int TAG_W = 4
);
    import ilm_pkg::*;

    // Handshake: a word moves on a rising clk edge where its valid and ready are both high.
    // A producer holding valid keeps its payload stable until that edge.
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [W-1:0]         x_i;
    logic [TAG_W-1:0]     tag_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [OH_W-1:0]      onehot_o;
    logic [EXP_W-1:0]     exp_o;
    logic [W-1:0]         res_o;
    logic                 zero_o;
    logic                 ovf_o;
    logic [TAG_W-1:0]     tag_o;

    modport slave (
        input  in_valid_i, x_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, onehot_o, exp_o, res_o, zero_o, ovf_o, tag_o
    );

    modport master (
        output in_valid_i, x_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, onehot_o, exp_o, res_o, zero_o, ovf_o, tag_o
    );

endinterface

// File: rtl/ilm_nod_stage_lod16.sv
// Combinational leading-one index of a 16-bit word; returns 0 for a zero input.
module lod16
    import ilm_pkg::*;
(
    input  logic [W-1:0]   x_i,
    output logic [P_W-1:0] p_o
);

    always_comb begin
        p_o = '0;
        for (int i = 1; i < W; i++) begin
            if (x_i[i]) p_o = P_W'(i);
        end
    end

endmodule

// File: rtl/ilm_nod_stage.sv
// Two-stage nearest-one detector: stage 1 finds the leading one, stage 2 rounds to 2^k.
module ilm_nod_stage
    import ilm_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input logic              clk,
    input logic              rst,
    ilm_nod_stage_if.slave   bus
);

    logic              v1_q, v2_q;
    logic              a1, a2;

    logic [W-1:0]      x1_q;
    logic [TAG_W-1:0]  tag1_q;
    logic              zero1_q;
    logic [P_W-1:0]    p1_q;
    logic [P_W-1:0]    p_d;

    nod_result_t       r2_q, r2_d;
    logic [TAG_W-1:0]  tag2_q;

    logic              below_bit;
    logic [EXP_W-1:0]  k_d;

    assign a2 = !v2_q || bus.out_ready_i;
    assign a1 = !v1_q || a2;

    lod16 u_lod (
        .x_i (bus.x_i),
        .p_o (p_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            if (a1) v1_q <= bus.in_valid_i;
            if (a2) v2_q <= v1_q;
        end
    end

    // Payload registers only load on a real transfer, so they hold while stalled.
    always_ff @(posedge clk) begin
        if (a1 && bus.in_valid_i) begin
            x1_q    <= bus.x_i;
            tag1_q  <= bus.tag_i;
            zero1_q <= (bus.x_i == '0);
            p1_q    <= p_d;
        end
        if (a2 && v1_q) begin
            r2_q   <= r2_d;
            tag2_q <= tag1_q;
        end
    end

    always_comb begin
        below_bit = (p1_q != '0) ? x1_q[p1_q - P_W'(1)] : 1'b0;
        k_d       = nearest_exp(p1_q, below_bit);
        r2_d      = '0;
        r2_d.exp  = k_d;
        r2_d.zero = zero1_q;
        r2_d.ovf  = (k_d == EXP_W'(W));
        // 16-bit wraparound makes k=16 subtract nothing, leaving res = x (already negative).
        r2_d.res  = zero1_q ? '0 : (x1_q - (W'(1) << k_d));
        if (k_d >= EXP_W'(1) && k_d <= EXP_W'(OH_W)) begin
            r2_d.onehot = OH_W'(1) << (k_d - EXP_W'(1));
        end
    end

    logic out_en;
    assign out_en = v2_q && !rst;

    assign bus.in_ready_o  = a1 && !rst;
    assign bus.out_valid_o = out_en;
    assign bus.onehot_o    = out_en ? r2_q.onehot : '0;
    assign bus.exp_o       = out_en ? r2_q.exp    : '0;
    assign bus.res_o       = out_en ? r2_q.res    : '0;
    assign bus.zero_o      = out_en ? r2_q.zero   : 1'b0;
    assign bus.ovf_o       = out_en ? r2_q.ovf    : 1'b0;
    assign bus.tag_o       = out_en ? tag2_q      : '0;

endmodule
